latch_bank: RTL and testbench

Parametrised, flop-based replacement for level-sensitive gated latches, built so latch-style designs map to emulation without real latch primitives. Holds CHANNELS independent WIDTH-bit values, each updated while its gate `i_en[c]` is high, and counts value changes per channel. A snapshot engine captures all channels atomically and streams them out one channel per beat over a valid/ready port. It sits between gated producers and any consumer that previously read raw latch outputs.

---
 rtl/latch_bank_pkg.sv | 16 +
 rtl/latch_bank_chan.sv | 36 +++
 rtl/latch_bank.sv | 110 +++++++++++
 tb/tb_latch_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types for latch_bank: snapshot FSM states and the channel-index width helper.
// Build option: LATCH_BANK_TRANSPARENT_EN selects latch-transparent o_q in latch_bank.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM
  } state_e;

  // Channel index width; a single channel still needs one index bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One latch_bank channel: gated hold register, change detector and saturating
// change counter with a capture-clear input that never drops a coincident change.
module latch_bank_chan #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_h,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic change;

  assign change = i_en && (i_d != o_h);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_h   <= '0;
      o_cnt <= '0;
    end else begin
      if (i_en) o_h <= i_d;
      // The clear restarts counting at 1 when a change lands in the capture cycle.
      if (i_clr) o_cnt <= change ? CNT_W'(1) : '0;
      else if (change && (o_cnt != CNT_MAX)) o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/latch_bank.sv
// Flop-based latch bank with per-channel change counters and an atomic snapshot
// streamed over valid/ready. Define LATCH_BANK_TRANSPARENT_EN for transparent o_q.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  parameter int  CNT_W    = 8,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic [CHANNELS*WIDTH-1:0] i_d,
  output logic [CHANNELS*WIDTH-1:0] o_q,
  input  logic                      i_snap_req,
  output logic                      o_snap_busy,
  output logic                      o_sv,
  input  logic                      i_sr,
  output logic [CNT_W+WIDTH-1:0]    o_sdata,
  output logic [CH_W-1:0]           o_sch,
  output logic                      o_slast
);

  localparam int              SW       = CNT_W + WIDTH;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CHANNELS - 1);

  logic [WIDTH-1:0] hold   [CHANNELS];
  logic [CNT_W-1:0] cnt    [CHANNELS];
  logic [SW-1:0]    shadow [CHANNELS];

  state_e          state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic            capture;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    latch_bank_chan #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_chan (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_en[c]),
      .i_d   (i_d[c*WIDTH +: WIDTH]),
      .i_clr (capture),
      .o_h   (hold[c]),
      .o_cnt (cnt[c])
    );

`ifdef LATCH_BANK_TRANSPARENT_EN
    assign o_q[c*WIDTH +: WIDTH] = i_en[c] ? i_d[c*WIDTH +: WIDTH] : hold[c];
`else
    assign o_q[c*WIDTH +: WIDTH] = hold[c];
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: defaults first so every path assigns every output; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (i_snap_req) state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (i_sr) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shadow array is reset on purpose: a mid-stream reset must leave no
  // stale snapshot behind, so it stays in flops rather than a RAM macro.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) shadow[c] <= '0;
    end else if (capture) begin
      for (int c = 0; c < CHANNELS; c++) shadow[c] <= {cnt[c], hold[c]};
    end
  end

  assign o_snap_busy = (state_q != IDLE);
  assign o_sv        = (state_q == STREAM);
  assign o_sdata     = o_sv ? shadow[idx_q] : '0;
  assign o_sch       = idx_q;
  assign o_slast     = o_sv && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_latch_bank.sv
// Directed self-checking bench for latch_bank (default parameters); expectations
// adapt to LATCH_BANK_TRANSPARENT_EN where o_q timing differs.
module tb_latch_bank;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;
  localparam int SW       = CNT_W + WIDTH;

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [CHANNELS-1:0]       i_en;
  logic [CHANNELS*WIDTH-1:0] i_d;
  logic [CHANNELS*WIDTH-1:0] o_q;
  logic                      i_snap_req;
  logic                      o_snap_busy;
  logic                      o_sv;
  logic                      i_sr;
  logic [SW-1:0]             o_sdata;
  logic [CH_W-1:0]           o_sch;
  logic                      o_slast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SW-1:0] exp_beat [CHANNELS];

  latch_bank #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_d        (i_d),
    .o_q        (o_q),
    .i_snap_req (i_snap_req),
    .o_snap_busy(o_snap_busy),
    .o_sv       (o_sv),
    .i_sr       (i_sr),
    .o_sdata    (o_sdata),
    .o_sch      (o_sch),
    .o_slast    (o_slast)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge for drive and sample.
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic set_d(input int c, input logic [WIDTH-1:0] v);
    i_d[c*WIDTH +: WIDTH] = v;
  endtask

  // Request sampled in IDLE; returns in CAPTURE.
  task automatic req_snap();
    i_snap_req = 1'b1;
    step();
    i_snap_req = 1'b0;
    check("busy_in_capture", 32'(o_snap_busy), 32'd1);
    check("sv_low_in_capture", 32'(o_sv), 32'd0);
  endtask

  // Runs the capture edge, then stream beats with ready taken cyclically from pat.
  task automatic stream(input logic [7:0] pat, input logic hold_req, input int stop_after);
    int idx = 0;
    int k   = 0;
    i_snap_req = hold_req;
    step();
    while (idx < CHANNELS && idx < stop_after && k < 64) begin
      check($sformatf("sv_beat%0d", idx), 32'(o_sv), 32'd1);
      check($sformatf("sch_beat%0d", idx), 32'(o_sch), 32'(idx));
      check($sformatf("sdata_ch%0d", idx), 32'(o_sdata), 32'(exp_beat[idx]));
      check($sformatf("slast_beat%0d", idx), 32'(o_slast), 32'(idx == CHANNELS - 1));
      i_sr = pat[k % 8];
      step();
      if (pat[k % 8]) idx++;
      k++;
    end
    i_snap_req = 1'b0;
    i_sr       = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_busy"}, 32'(o_snap_busy), 32'd0);
    check({tag, "_sv"}, 32'(o_sv), 32'd0);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_en       = '0;
    i_d        = $urandom();
    i_snap_req = 1'b0;
    i_sr       = 1'b0;
    #12;
    check("rst_q", o_q, 32'd0);
    check("rst_busy", 32'(o_snap_busy), 32'd0);
    check("rst_sv", 32'(o_sv), 32'd0);
    check("rst_sdata", 32'(o_sdata), 32'd0);
    check("rst_sch", 32'(o_sch), 32'd0);
    check("rst_slast", 32'(o_slast), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Gates closed: random data must not reach the holds or the counters.
    for (int i = 0; i < 3; i++) begin
      i_d = $urandom();
      step();
      check("closed_q", o_q, 32'd0);
    end
    for (int c = 0; c < CHANNELS; c++) exp_beat[c] = '0;
    req_snap();
    stream(8'hFF, 1'b0, CHANNELS);
    expect_idle("after_snap0");

    // Channel 0: 0x5A for three edges, then 0xA5 once -> two changes.
    i_d = '0;
    i_en = 4'b0001;
    set_d(0, 8'h5A);
    #1;
`ifdef LATCH_BANK_TRANSPARENT_EN
    check("q0_same_cycle", 32'(o_q[7:0]), 32'h5A);
`else
    check("q0_same_cycle", 32'(o_q[7:0]), 32'h00);
`endif
    step();
    check("q0_after_edge", 32'(o_q[7:0]), 32'h5A);
    step();
    step();
    set_d(0, 8'hA5);
    step();
    i_en = '0;
    check("q0_final", 32'(o_q[7:0]), 32'hA5);

    // Channel 1: 300 alternating changes saturate the 8-bit counter.
    i_en = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      set_d(1, (i % 2 != 0) ? 8'h02 : 8'h01);
      step();
    end
    i_en = '0;
    exp_beat[0] = {8'd2, 8'hA5};
    exp_beat[1] = {8'd255, 8'h02};
    exp_beat[2] = '0;
    exp_beat[3] = '0;
    req_snap();
    stream(8'hFF, 1'b0, CHANNELS);
    expect_idle("after_snap1");

    // Counters were cleared; stall with ready 1,0,0,1,... and a request held while busy.
    exp_beat[0] = {8'd0, 8'hA5};
    exp_beat[1] = {8'd0, 8'h02};
    req_snap();
    stream(8'b1011_1001, 1'b1, CHANNELS);
    expect_idle("busy_req_ignored");
    step();
    expect_idle("busy_req_ignored_late");

    // Channel 2: two changes, then a third landing exactly in the capture cycle.
    i_en = 4'b0100;
    set_d(2, 8'h11);
    step();
    set_d(2, 8'h22);
    step();
    i_en = '0;
    req_snap();
    i_en = 4'b0100;
    set_d(2, 8'h33);
    exp_beat[2] = {8'd2, 8'h22};
    stream(8'hFF, 1'b0, CHANNELS);
    i_en = '0;
    check("q2_after_capture", 32'(o_q[23:16]), 32'h33);
    exp_beat[2] = {8'd1, 8'h33};
    req_snap();
    stream(8'hFF, 1'b0, CHANNELS);
    expect_idle("after_snap4");

    // Reset after beat 1 is accepted; request held while busy must not resurface.
    exp_beat[2] = {8'd0, 8'h33};
    req_snap();
    stream(8'hFF, 1'b1, 2);
    check("pre_rst_sv", 32'(o_sv), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_sv", 32'(o_sv), 32'd0);
    check("mid_rst_busy", 32'(o_snap_busy), 32'd0);
    check("mid_rst_q", o_q, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("post_rst");
    end
    for (int c = 0; c < CHANNELS; c++) exp_beat[c] = '0;
    req_snap();
    stream(8'hFF, 1'b0, CHANNELS);
    expect_idle("after_rst_snap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
